// File: rtl/mant_div_seq_ctrl.sv
// mant_div_seq_ctrl: iterative restoring divider for the 24-bit FP_Div mantissa.
// Each CALC clock retires STEPS_PER_CYCLE quotient bits (MSB first). Results are
// presented to normalize/round with a one-cycle out_valid pulse in DONE.
// Optional feature: define MANT_DIV_EARLY_TERM_EN to finish as soon as the
// partial remainder becomes zero (remaining quotient bits are zero-filled).
module mant_div_seq_ctrl #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_start,
    input  logic        in_flush,
    input  logic [24:0] in_dividend,
    input  logic [23:0] in_divisor,
    output logic        out_ready,
    output logic        out_busy,
    output logic        out_valid,
    output logic [23:0] out_quotient,
    output logic [24:0] out_remainder,
    output logic        out_sticky,
    output logic        out_dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] r_q, r_d;          // partial remainder, kept pre-shifted by one
    logic [23:0] d_q, d_d;          // latched divisor
    logic [23:0] q_q, q_d;          // quotient being assembled
    logic [4:0]  cnt_q, cnt_d;      // quotient bits retired so far
    logic        dzpend_q, dzpend_d; // accepted op had a zero divisor
    logic [23:0] quo_q, quo_d;
    logic [24:0] rem_q, rem_d;
    logic        sticky_q, sticky_d;
    logic        dz_q, dz_d;

    logic [24:0] r_step;
    logic [23:0] q_step;
    logic [4:0]  cnt_step;

    // Shared step array: STEPS_PER_CYCLE chained restoring compare/subtract stages.
    always_comb begin
        r_step = r_q;
        q_step = q_q;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (r_step >= {1'b0, d_q}) begin
                r_step = (r_step - {1'b0, d_q}) << 1;
                q_step = {q_step[22:0], 1'b1};
            end else begin
                r_step = r_step << 1;
                q_step = {q_step[22:0], 1'b0};
            end
        end
        cnt_step = cnt_q + 5'(STEPS_PER_CYCLE);
    end

    // Next-state and register-update logic; result registers only load on entry to DONE.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        d_d      = d_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        dzpend_d = dzpend_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (in_start) begin
                    r_d      = in_dividend;
                    d_d      = in_divisor;
                    q_d      = '0;
                    cnt_d    = '0;
                    dzpend_d = (in_divisor == '0);
                    dz_d     = 1'b0;
                    state_d  = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (in_flush) begin
                    state_d = IDLE;
                end else if (dzpend_q) begin
                    // Zero divisor: saturate quotient, pass dividend through as remainder.
                    quo_d    = 24'hFFFFFF;
                    rem_d    = r_q;
                    sticky_d = 1'b1;
                    dz_d     = 1'b1;
                    state_d  = DONE;
                end else begin
                    r_d   = r_step;
                    q_d   = q_step;
                    cnt_d = cnt_step;
                    if (cnt_step == 5'd24) begin
                        quo_d    = q_step;
                        rem_d    = {1'b0, r_step[24:1]};
                        sticky_d = |r_step;
                        state_d  = DONE;
                    end
`ifdef MANT_DIV_EARLY_TERM_EN
                    else if (r_step == '0) begin
                        // Exact result: the outstanding quotient bits are all zero.
                        quo_d    = q_step << (5'd24 - cnt_step);
                        rem_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = DONE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= IDLE;
            r_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            dzpend_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            d_q      <= d_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            dzpend_q <= dzpend_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end

    assign out_ready     = (state_q != CALC);
    assign out_busy      = (state_q == CALC);
    assign out_valid     = (state_q == DONE);
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;
    assign out_sticky    = sticky_q;
    assign out_dz        = dz_q;

endmodule

// File: tb/tb_mant_div_seq_ctrl.sv
// Testbench for mant_div_seq_ctrl: one instance with 1 step/clock, one with 4.
// Expected results come from a long-division reference (quotient = dividend*2^23/divisor).
module tb_mant_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st1 = 1'b0, st4 = 1'b0, flush = 1'b0;
    logic [24:0] dividend = '0;
    logic [23:0] divisor = '0;
    logic        sel4 = 1'b0;

    logic        rdy1, bsy1, vld1, stk1, dz1;
    logic [23:0] quo1;
    logic [24:0] rem1;
    logic        rdy4, bsy4, vld4, stk4, dz4;
    logic [23:0] quo4;
    logic [24:0] rem4;

    logic        m_ready, m_busy, m_valid, m_sticky, m_dz;
    logic [23:0] m_quo;
    logic [24:0] m_rem;

    int tests = 0;
    int fails = 0;
    logic [23:0] last_q;
    logic [24:0] last_r;
    logic        last_s;

    always #5 clk = ~clk;

    mant_div_seq_ctrl #(.STEPS_PER_CYCLE(1)) dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(st1), .in_flush(flush),
        .in_dividend(dividend), .in_divisor(divisor),
        .out_ready(rdy1), .out_busy(bsy1), .out_valid(vld1),
        .out_quotient(quo1), .out_remainder(rem1), .out_sticky(stk1), .out_dz(dz1)
    );

    mant_div_seq_ctrl #(.STEPS_PER_CYCLE(4)) dut4 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(st4), .in_flush(flush),
        .in_dividend(dividend), .in_divisor(divisor),
        .out_ready(rdy4), .out_busy(bsy4), .out_valid(vld4),
        .out_quotient(quo4), .out_remainder(rem4), .out_sticky(stk4), .out_dz(dz4)
    );

    assign m_ready  = sel4 ? rdy4 : rdy1;
    assign m_busy   = sel4 ? bsy4 : bsy1;
    assign m_valid  = sel4 ? vld4 : vld1;
    assign m_quo    = sel4 ? quo4 : quo1;
    assign m_rem    = sel4 ? rem4 : rem1;
    assign m_sticky = sel4 ? stk4 : stk1;
    assign m_dz     = sel4 ? dz4  : dz1;

    // Reference model
    function automatic logic [23:0] ref_quo(input longint unsigned a, input longint unsigned b);
        if (b == 0) return 24'hFFFFFF;
        return 24'((a << 23) / b);
    endfunction

    function automatic logic [24:0] ref_rem(input longint unsigned a, input longint unsigned b);
        if (b == 0) return 25'(a);
        return 25'((a << 23) % b);
    endfunction

    function automatic int ref_lat(input longint unsigned a, input longint unsigned b, input int s);
        if (b == 0) return 1;
`ifdef MANT_DIV_EARLY_TERM_EN
        for (int c = 1; c < 24 / s; c++)
            if (((a << (c * s - 1)) % b) == 0) return c;
`endif
        return 24 / s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int s);
        if (s == 4) st4 = 1'b1;
        else        st1 = 1'b1;
    endtask

    // Issue one divide (caller is mid-cycle), wait for valid, check results and timing.
    task automatic run_op(input string tag, input int s, input logic [24:0] a, input logic [23:0] b,
                          input logic [23:0] eq, input logic [24:0] er, input logic es,
                          input logic edz, input int poke);
        int k, bc, lat;
        lat = ref_lat(longint'(a), longint'(b), s);
        sel4 = (s == 4);
        dividend = a;
        divisor = b;
        pulse_start(s);
        @(posedge clk); #1;
        st1 = 1'b0; st4 = 1'b0;
        dividend = 25'h1ABCDE;
        divisor = 24'h000123;
        k = 0; bc = 0;
        while (!m_valid && k < 60) begin
            if (m_busy) bc++;
            if (k == poke) pulse_start(s);
            @(posedge clk); #1;
            st1 = 1'b0; st4 = 1'b0;
            k++;
        end
        chk({tag, " latency"}, 64'(k), 64'(lat));
        if (b != 0) chk({tag, " busy cycles"}, 64'(bc), 64'(lat));
        chk({tag, " quotient"}, 64'(m_quo), 64'(eq));
        chk({tag, " remainder"}, 64'(m_rem), 64'(er));
        chk({tag, " sticky"}, 64'(m_sticky), 64'(es));
        chk({tag, " dz"}, 64'(m_dz), 64'(edz));
        chk({tag, " ready in DONE"}, 64'(m_ready), 64'd1);
        last_q = eq; last_r = er; last_s = es;
    endtask

    task automatic no_valid(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (m_valid) cnt++;
        end
        chk({tag, " spurious valid"}, 64'(cnt), 64'd0);
    endtask

    typedef struct {
        int          s;
        logic [24:0] a;
        logic [23:0] b;
        logic [23:0] q;
        logic [24:0] r;
        logic        st;
        logic        dz;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 25'h0C00000, 24'h800000, 24'hC00000, 25'h0000000, 1'b0, 1'b0};
        tbl[1] = '{1, 25'h0800000, 24'hC00000, 24'h555555, 25'h0400000, 1'b1, 1'b0};
        tbl[2] = '{4, 25'h0800000, 24'hC00000, 24'h555555, 25'h0400000, 1'b1, 1'b0};
        tbl[3] = '{1, 25'h0900000, 24'h000000, 24'hFFFFFF, 25'h0900000, 1'b1, 1'b1};
        tbl[4] = '{4, 25'h0900000, 24'h000000, 24'hFFFFFF, 25'h0900000, 1'b1, 1'b1};
        tbl[5] = '{1, 25'h0FFFFFF, 24'h800000, 24'hFFFFFF, 25'h0000000, 1'b0, 1'b0};
        tbl[6] = '{4, 25'h1000000, 24'h800001, 24'hFFFFFE, 25'h0000002, 1'b1, 1'b0};

        // Reset state
        #3;
        chk("reset ready", 64'(rdy1), 64'd1);
        chk("reset busy", 64'(bsy1), 64'd0);
        chk("reset valid", 64'(vld1), 64'd0);
        chk("reset quotient", 64'(quo1), 64'd0);
        chk("reset remainder", 64'(rem1), 64'd0);
        chk("reset sticky/dz", 64'({stk1, dz1}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b,
                   tbl[i].q, tbl[i].r, tbl[i].st, tbl[i].dz, -1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid pulse width", i), 64'(m_valid), 64'd0);
            chk($sformatf("vec%0d held quotient", i), 64'(m_quo), 64'(tbl[i].q));
            chk($sformatf("vec%0d idle ready", i), 64'(m_ready), 64'd1);
        end

        // Back-to-back: second start issued during the DONE cycle
        @(negedge clk);
        run_op("b2b first", 1, 25'h0800000, 24'hC00000, 24'h555555, 25'h0400000, 1'b1, 1'b0, -1);
        run_op("b2b second", 1, 25'h1000000, 24'h800001, 24'hFFFFFE, 25'h0000002, 1'b1, 1'b0, -1);
        @(posedge clk); #1;
        chk("b2b pulse width", 64'(m_valid), 64'd0);

        // Start asserted mid-CALC is ignored
        @(negedge clk);
        run_op("calc start", 1, 25'h0800000, 24'hC00000, 24'h555555, 25'h0400000, 1'b1, 1'b0, 5);
        no_valid("calc start", 30);

        // Flush at CALC cycle 10 (start also raised to confirm flush priority)
        @(negedge clk);
        sel4 = 1'b0;
        dividend = 25'h0C00000; divisor = 24'hA00000;
        st1 = 1'b1;
        @(posedge clk); #1; st1 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush pre busy", 64'(m_busy), 64'd1);
        flush = 1'b1; st1 = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; st1 = 1'b0;
        chk("flush ready", 64'(m_ready), 64'd1);
        chk("flush busy", 64'(m_busy), 64'd0);
        chk("flush held quotient", 64'(m_quo), 64'(last_q));
        chk("flush held remainder", 64'(m_rem), 64'(last_r));
        chk("flush held sticky", 64'(m_sticky), 64'(last_s));
        no_valid("flush", 30);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        dividend = 25'h0800000; divisor = 24'hC00000;
        st1 = 1'b1;
        @(posedge clk); #1; st1 = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("async rst ready", 64'(rdy1), 64'd1);
        chk("async rst busy", 64'(bsy1), 64'd0);
        chk("async rst valid", 64'(vld1), 64'd0);
        chk("async rst outputs", 64'({quo1, rem1, stk1, dz1}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Randomized divides against the reference model
        for (int i = 0; i < 30; i++) begin
            int s;
            longint unsigned a, b;
            s = ($urandom % 2 == 0) ? 1 : 4;
            if (i % 3 == 0) b = longint'($urandom_range(1, 24'hFFFFFF));
            else            b = longint'(($urandom & 32'hFFFFFF) | 32'h800000);
            a = longint'({$urandom, $urandom}) % (2 * b);
            if (i % 7 == 0) a = (b << ($urandom % 2)) & 64'h1FFFFFF;
            if (a >= 2 * b) a = b;
            @(negedge clk);
            run_op($sformatf("rand%0d", i), s, 25'(a), 24'(b),
                   ref_quo(a, b), ref_rem(a, b), (ref_rem(a, b) != 0), 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
